// File: rtl/cpu_pkg.sv
// Shared CPU definitions: divider FSM states and the derived timing constants
// used by the DIV/DIVU path and its neighbours.
package cpu_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 2;
    localparam int DIV_CNT_W   = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only if it is non-negative.
module div_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] trial_s;
    logic [WIDTH:0] diff_s;

    // Trial subtraction on the widened partial remainder; the result always fits WIDTH bits
    always_comb begin
        trial_s = {rem_in, dvd_msb};
        diff_s  = trial_s - {1'b0, divisor};
        if (trial_s >= {1'b0, divisor}) begin
            q_bit   = 1'b1;
            rem_out = diff_s[WIDTH-1:0];
        end else begin
            q_bit   = 1'b0;
            rem_out = trial_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/div_seq.sv
// Iterative signed/unsigned divider (DIV/DIVU): magnitude restoring division,
// one quotient bit per clock, sign fix-up in a final cycle. Fixed latency.
module div_seq
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    div_state_t       state_r;
    div_state_t       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dsr_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quot_r;
    logic             sign_q_r;
    logic             sign_r_r;
    logic             dbz_pend_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;
    logic [WIDTH-1:0] step_rem_s;
    logic             step_q_s;

    // Two's-complement negate when en is set; MIN maps to itself, which is the
    // desired unsigned magnitude of MIN and the desired wrap for MIN / -1.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
        if (en) begin
            cond_neg = ~v + W_ONE;
        end else begin
            cond_neg = v;
        end
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_r),
        .dvd_msb (dvd_r[WIDTH-1]),
        .divisor (dsr_r),
        .rem_out (step_rem_s),
        .q_bit   (step_q_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and registered results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r      <= {CNT_W{1'b0}};
            dvd_r      <= {WIDTH{1'b0}};
            dsr_r      <= {WIDTH{1'b0}};
            rem_r      <= {WIDTH{1'b0}};
            quot_r     <= {WIDTH{1'b0}};
            sign_q_r   <= 1'b0;
            sign_r_r   <= 1'b0;
            dbz_pend_r <= 1'b0;
            q_r        <= {WIDTH{1'b0}};
            r_r        <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dbz_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        busy_r     <= 1'b1;
                        dbz_r      <= 1'b0;
                        dbz_pend_r <= (b == {WIDTH{1'b0}});
                        cnt_r      <= CNT_MAX;
                        rem_r      <= {WIDTH{1'b0}};
                        quot_r     <= {WIDTH{1'b0}};
                        dvd_r      <= cond_neg(a, is_signed & a[WIDTH-1]);
                        dsr_r      <= cond_neg(b, is_signed & b[WIDTH-1]);
                        sign_q_r   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sign_r_r   <= is_signed & a[WIDTH-1];
                    end
                end
                CALC: begin
                    rem_r  <= step_rem_s;
                    quot_r <= {quot_r[WIDTH-2:0], step_q_s};
                    dvd_r  <= {dvd_r[WIDTH-2:0], 1'b0};
                    cnt_r  <= cnt_r - CNT_ONE;
                end
                FIX: begin
                    // A zero divisor leaves the full dividend magnitude in rem_r,
                    // so the sign-corrected remainder is the original dividend.
                    q_r    <= dbz_pend_r ? {WIDTH{1'b1}} : cond_neg(quot_r, sign_q_r);
                    r_r    <= cond_neg(rem_r, sign_r_r);
                    dbz_r  <= dbz_pend_r;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign q           = q_r;
    assign r           = r_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vector table, handshake corner
// sequences and randomized operands against an arithmetic reference model.
module tb_div_seq;
    import cpu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    div_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .a           (a),
        .b           (b),
        .q           (q),
        .r           (r),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
        logic        edbz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic (truncating division, remainder with dividend sign)
    function automatic void ref_div(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] eq, output logic [31:0] er);
        longint sx;
        longint sy;
        if (y == 32'd0) begin
            eq = 32'hFFFF_FFFF;
            er = x;
        end else begin
            if (sgn) begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
            end else begin
                sx = longint'({32'd0, x});
                sy = longint'({32'd0, y});
            end
            eq = 32'(sx / sy);
            er = 32'(sx % sy);
        end
    endfunction

    task automatic launch(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        start     = 1'b1;
        is_signed = sgn;
        a         = x;
        b         = y;
    endtask

    // Called right after launch at a negedge; returns at the negedge where done is seen
    task automatic wait_done(input int poke_at, output logic [31:0] rq, output logic [31:0] rr,
                             output logic rdbz, output int lat, output int bcnt);
        int n;
        logic got;
        n = 0;
        bcnt = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            start     = (n == poke_at);
            a         = $urandom;
            b         = $urandom;
            is_signed = 1'($urandom_range(0, 1));
            if (busy) bcnt++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        lat   = got ? n : -1;
        rq    = q;
        rr    = r;
        rdbz  = div_by_zero;
    endtask

    initial begin
        logic [31:0] gq;
        logic [31:0] gr;
        logic        gdbz;
        int          lat;
        int          bcnt;
        logic [31:0] eq;
        logic [31:0] er;
        logic [31:0] x;
        logic [31:0] y;
        logic        sg;
        int          ndone;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0};
        vecs[1] = '{1'b1, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
        vecs[2] = '{1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,        1'b0};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0};
        vecs[4] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0};
        vecs[5] = '{1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        1'b1};
        vecs[6] = '{1'b1, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        1'b1};
        vecs[7] = '{1'b0, 32'd9,          32'd3,        32'd3,        32'd0,        1'b0};
        vecs[8] = '{1'b1, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1};
        vecs[9] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        a = 32'd0;
        b = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_q", q, 32'd0);
        check("reset_r", r, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            launch(vecs[i].sgn, vecs[i].a, vecs[i].b);
            wait_done(-1, gq, gr, gdbz, lat, bcnt);
            check($sformatf("vec%0d_q", i), gq, vecs[i].eq);
            check($sformatf("vec%0d_r", i), gr, vecs[i].er);
            check($sformatf("vec%0d_dbz", i), 32'(gdbz), 32'(vecs[i].edbz));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(DIV_LATENCY));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(W + 1));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
        end

        // start pulsed mid-divide is ignored; then a start in the done cycle is accepted
        @(negedge clk);
        launch(1'b0, 32'd1000, 32'd33);
        wait_done(5, gq, gr, gdbz, lat, bcnt);
        check("ignored_start_q", gq, 32'd30);
        check("ignored_start_r", gr, 32'd10);
        check("ignored_start_latency", 32'(lat), 32'(DIV_LATENCY));
        launch(1'b1, 32'hFFFF_FC18, 32'd33);
        wait_done(-1, gq, gr, gdbz, lat, bcnt);
        check("b2b_q", gq, 32'hFFFF_FFE2);
        check("b2b_r", gr, 32'hFFFF_FFF6);
        check("b2b_latency", 32'(lat), 32'(DIV_LATENCY));

        // reset in the middle of a divide
        @(negedge clk);
        launch(1'b0, 32'hDEAD_BEEF, 32'd3);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_q", q, 32'd0);
        check("midrst_r", r, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        launch(1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_done(-1, gq, gr, gdbz, lat, bcnt);
        check("postrst_q", gq, 32'hFFFF_FFFF);
        check("postrst_r", gr, 32'd0);
        check("postrst_latency", 32'(lat), 32'(DIV_LATENCY));

        // randomized operands with occasional boundary values
        for (int k = 0; k < 150; k++) begin
            sg = 1'($urandom_range(0, 1));
            x  = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'($urandom_range(0, 15));
                1: y = 32'hFFFF_FFFF;
                2: y = 32'h8000_0000;
                3: y = $urandom >> $urandom_range(0, 31);
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
            ref_div(sg, x, y, eq, er);
            @(negedge clk);
            launch(sg, x, y);
            wait_done(-1, gq, gr, gdbz, lat, bcnt);
            check($sformatf("rnd%0d_q s=%0d a=%h b=%h", k, sg, x, y), gq, eq);
            check($sformatf("rnd%0d_r s=%0d a=%h b=%h", k, sg, x, y), gr, er);
            check($sformatf("rnd%0d_dbz", k), 32'(gdbz), 32'(y == 32'd0));
            check($sformatf("rnd%0d_latency", k), 32'(lat), 32'(DIV_LATENCY));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
